// File: rtl/bus_responder_pkg.sv
// Shared types and address-map constants for the CPU memory-bus responder.
package bus_responder_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [1:0]  REGION_IO       = 2'b11;
    localparam logic [1:0]  REGION_UNMAPPED = 2'b10;
    localparam logic [17:0] IO_PORT_ADDR    = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR     = 18'h30004;

    typedef enum logic [1:0] {
        REG_RAM      = 2'd0,
        REG_IO       = 2'd1,
        REG_UNMAPPED = 2'd2
    } region_e;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_IO   = 2'd2
    } rd_src_e;

    function automatic region_e decodeRegion(input logic [1:0] topBits);
        region_e r;
        case (topBits)
            REGION_IO:       r = REG_IO;
            REGION_UNMAPPED: r = REG_UNMAPPED;
            default:         r = REG_RAM;
        endcase
        return r;
    endfunction

    function automatic byte_t wordByte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU memory bus plus RX/TX byte streams and status, as seen by the responder.
interface bus_responder_if;
    import bus_responder_pkg::*;

    logic [31:0] bus_a_in;
    logic        bus_wr_in;
    byte_t       bus_din_in;
    byte_t       bus_dout_out;
    logic        cpu_rdy_out;
    logic        rx_valid_in;
    byte_t       rx_data_in;
    logic        rx_ready_out;
    logic        tx_valid_out;
    byte_t       tx_data_out;
    logic        tx_ready_in;
    logic        halted_out;

    modport master (
        output bus_a_in, bus_wr_in, bus_din_in, rx_valid_in, rx_data_in, tx_ready_in,
        input  bus_dout_out, cpu_rdy_out, rx_ready_out, tx_valid_out, tx_data_out, halted_out
    );

    modport slave (
        input  bus_a_in, bus_wr_in, bus_din_in, rx_valid_in, rx_data_in, tx_ready_in,
        output bus_dout_out, cpu_rdy_out, rx_ready_out, tx_valid_out, tx_data_out, halted_out
    );
endinterface

// File: rtl/bus_responder_byte_fifo.sv
// Byte FIFO with occupancy count; push and pop may coincide in any state,
// a push while full only lands when the same-cycle pop frees a slot.
module byte_fifo
    import bus_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  byte_t                    pushData,
    input  logic                     pop,
    output byte_t                    popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    byte_t         mem_r [DEPTH];
    logic [PW-1:0] wrPtr_r;
    logic [PW-1:0] rdPtr_r;
    logic [PW:0]   count_r;
    logic          doPush_s;
    logic          doPop_s;

    // Qualify requests against current occupancy.
    always_comb begin
        doPop_s  = 1'b0;
        doPush_s = 1'b0;
        if (count_r != '0) begin
            doPop_s = pop;
        end else begin
            doPop_s = 1'b0;
        end
        if ((count_r != FULL_COUNT) || doPop_s) begin
            doPush_s = push;
        end else begin
            doPush_s = 1'b0;
        end
    end

    // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
        end else begin
            if (doPush_s) wrPtr_r <= wrPtr_r + 1'b1;
            if (doPop_s)  rdPtr_r <= rdPtr_r + 1'b1;
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (doPush_s) mem_r[wrPtr_r] <= pushData;
    end

    assign popData = mem_r[rdPtr_r];
    assign full    = (count_r == FULL_COUNT);
    assign empty   = (count_r == '0);
    assign count   = count_r;

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder: 128 KB byte RAM plus the I/O window (RX/TX byte FIFOs,
// cycle counter with snapshot, halt latch) on the CPU's byte-wide bus.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int RAM_AW     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk_in,
    input  logic           rst_in,
    bus_responder_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] RDY_LIMIT = CW'(FIFO_DEPTH - 1);

    byte_t         ram_r [0:(2**RAM_AW)-1];
    byte_t         ramRd_r;
    byte_t         ioRd_r;
    rd_src_e       rdSrc_r;
    logic [31:0]   counter_r;
    logic [31:0]   snap_r;
    logic          halted_r;
    logic          rdy_r;
    logic          live_r;

    logic [17:0]   addr_s;
    region_e       region_s;
    logic          ramWe_s;
    logic          txPush_s;
    byte_t         txPushData_s;
    logic          rxPop_s;
    logic          snapLoad_s;
    logic          haltSet_s;
    byte_t         ioRdData_s;
    rd_src_e       rdSrc_s;
    byte_t         dout_s;

    logic          rxPush_s;
    logic          rxReady_s;
    byte_t         rxHead_s;
    logic          rxFull_s;
    logic          rxEmpty_s;
    logic [CW-1:0] rxCount_s;
    logic          txPop_s;
    byte_t         txHead_s;
    logic          txFull_s;
    logic          txEmpty_s;
    logic [CW-1:0] txCount_s;
    logic          unusedBits_s;

    assign addr_s       = bus.bus_a_in[17:0];
    assign unusedBits_s = ^{bus.bus_a_in[31:18], rxCount_s, txFull_s};

    // RX stays closed until the first clock after reset release.
    assign rxReady_s = live_r && !rxFull_s;
    assign rxPush_s  = bus.rx_valid_in && rxReady_s;
    assign txPop_s   = !txEmpty_s && bus.tx_ready_in;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) rxFifo (
        .clk(clk_in), .rst(rst_in),
        .push(rxPush_s), .pushData(bus.rx_data_in),
        .pop(rxPop_s), .popData(rxHead_s),
        .full(rxFull_s), .empty(rxEmpty_s), .count(rxCount_s)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) txFifo (
        .clk(clk_in), .rst(rst_in),
        .push(txPush_s), .pushData(txPushData_s),
        .pop(txPop_s), .popData(txHead_s),
        .full(txFull_s), .empty(txEmpty_s), .count(txCount_s)
    );

    // Address decode: write side effects and read source/data selection.
    always_comb begin
        region_s     = decodeRegion(addr_s[17:16]);
        ramWe_s      = 1'b0;
        txPush_s     = 1'b0;
        txPushData_s = bus.bus_din_in;
        rxPop_s      = 1'b0;
        snapLoad_s   = 1'b0;
        haltSet_s    = 1'b0;
        ioRdData_s   = 8'h00;
        rdSrc_s      = SRC_ZERO;
        if (bus.bus_wr_in) begin
            if (!halted_r) begin
                case (region_s)
                    REG_RAM: ramWe_s = 1'b1;
                    REG_IO: begin
                        if (addr_s == IO_PORT_ADDR) begin
                            txPush_s = (bus.bus_din_in != 8'h00);
                        end else if (addr_s == IO_CLK_ADDR) begin
                            txPush_s     = 1'b1;
                            txPushData_s = 8'h00;
                            haltSet_s    = 1'b1;
                        end else begin
                            txPush_s = 1'b0;
                        end
                    end
                    default: ramWe_s = 1'b0;
                endcase
            end else begin
                ramWe_s = 1'b0;
            end
        end else begin
            case (region_s)
                REG_RAM: rdSrc_s = SRC_RAM;
                REG_IO: begin
                    rdSrc_s = SRC_IO;
                    if (addr_s == IO_PORT_ADDR) begin
                        rxPop_s    = !rxEmpty_s;
                        ioRdData_s = rxEmpty_s ? 8'h00 : rxHead_s;
                    end else if (addr_s == IO_CLK_ADDR) begin
                        snapLoad_s = 1'b1;
                        ioRdData_s = counter_r[7:0];
                    end else if (addr_s[17:2] == IO_CLK_ADDR[17:2]) begin
                        ioRdData_s = wordByte(snap_r, addr_s[1:0]);
                    end else begin
                        ioRdData_s = 8'h00;
                    end
                end
                default: rdSrc_s = SRC_ZERO;
            endcase
        end
    end

    // RAM array write port and registered read port (contents survive reset).
    always_ff @(posedge clk_in) begin
        if (ramWe_s) ram_r[addr_s[RAM_AW-1:0]] <= bus.bus_din_in;
        if (rdSrc_s == SRC_RAM && !bus.bus_wr_in) ramRd_r <= ram_r[addr_s[RAM_AW-1:0]];
    end

    // Control/status state; read source and I/O data only move on read cycles.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdSrc_r   <= SRC_ZERO;
            ioRd_r    <= 8'h00;
            counter_r <= 32'h0000_0000;
            snap_r    <= 32'h0000_0000;
            halted_r  <= 1'b0;
            rdy_r     <= 1'b0;
            live_r    <= 1'b0;
        end else begin
            counter_r <= counter_r + 32'd1;
            live_r    <= 1'b1;
            // Drop ready once at most one slot is free; the remaining slot absorbs
            // the write the CPU may already have issued this cycle.
            rdy_r     <= (txCount_s < RDY_LIMIT);
            if (!bus.bus_wr_in) begin
                rdSrc_r <= rdSrc_s;
                ioRd_r  <= ioRdData_s;
            end
            if (snapLoad_s) snap_r   <= counter_r;
            if (haltSet_s)  halted_r <= 1'b1;
        end
    end

    // Output read mux over registered source and data.
    always_comb begin
        dout_s = 8'h00;
        case (rdSrc_r)
            SRC_RAM: dout_s = ramRd_r;
            SRC_IO:  dout_s = ioRd_r;
            default: dout_s = 8'h00;
        endcase
    end

    assign bus.bus_dout_out = dout_s;
    assign bus.cpu_rdy_out  = rdy_r;
    assign bus.rx_ready_out = rxReady_s;
    assign bus.tx_valid_out = !txEmpty_s;
    assign bus.tx_data_out  = txEmpty_s ? 8'h00 : txHead_s;
    assign bus.halted_out   = halted_r;

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: RAM, RX/TX FIFOs, counter, halt, reset.
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] tbCycles;
    logic [31:0] snapN;
    int          budget;

    bus_responder_if bif();

    bus_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release, i.e. the expected counter value.
    always @(posedge clk or posedge rst) begin
        if (rst) tbCycles <= 32'd0;
        else     tbCycles <= tbCycles + 32'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkBit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic checkByte(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%02h exp=0x%02h", tag, got, exp);
        end
    endtask

    task automatic busIdle();
        bif.bus_a_in   = 32'h0002_0000;
        bif.bus_wr_in  = 1'b0;
        bif.bus_din_in = 8'h00;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [7:0] d);
        bif.bus_a_in   = a;
        bif.bus_wr_in  = 1'b1;
        bif.bus_din_in = d;
        step();
        busIdle();
    endtask

    task automatic busRead(input logic [31:0] a);
        bif.bus_a_in  = a;
        bif.bus_wr_in = 1'b0;
        step();
        busIdle();
    endtask

    task automatic rxPush(input logic [7:0] d);
        bif.rx_valid_in = 1'b1;
        bif.rx_data_in  = d;
        step();
        bif.rx_valid_in = 1'b0;
    endtask

    initial begin
        busIdle();
        bif.rx_valid_in = 1'b0;
        bif.rx_data_in  = 8'h00;
        bif.tx_ready_in = 1'b0;
        step();
        step();
        checkByte("rst_dout", bif.bus_dout_out, 8'h00);
        checkBit("rst_rdy", bif.cpu_rdy_out, 1'b0);
        checkBit("rst_rxrdy", bif.rx_ready_out, 1'b0);
        checkBit("rst_txvalid", bif.tx_valid_out, 1'b0);
        checkByte("rst_txdata", bif.tx_data_out, 8'h00);
        checkBit("rst_halted", bif.halted_out, 1'b0);
        rst = 1'b0;
        step();
        checkBit("rel_rdy", bif.cpu_rdy_out, 1'b1);
        checkBit("rel_rxrdy", bif.rx_ready_out, 1'b1);

        // RAM write/read, hold across writes, boundaries, aliasing, unmapped
        busWrite(32'h0000_0010, 8'hA5);
        busRead(32'h0000_0010);
        checkByte("ram_rd", bif.bus_dout_out, 8'hA5);
        busWrite(32'h0000_0020, 8'h5A);
        checkByte("ram_wr_hold", bif.bus_dout_out, 8'hA5);
        busRead(32'h0000_0020);
        checkByte("ram_rd2", bif.bus_dout_out, 8'h5A);
        busWrite(32'h0001_FFFF, 8'hC3);
        busRead(32'h0001_FFFF);
        checkByte("ram_top", bif.bus_dout_out, 8'hC3);
        busRead(32'hFFF0_0010);
        checkByte("ram_alias", bif.bus_dout_out, 8'hA5);
        busWrite(32'h0002_0010, 8'h99);
        busRead(32'h0002_0010);
        checkByte("unmap_rd", bif.bus_dout_out, 8'h00);
        busRead(32'h0000_0010);
        checkByte("unmap_wr_drop", bif.bus_dout_out, 8'hA5);

        // RX FIFO reads, underflow, empty push+pop, full
        rxPush(8'h41);
        rxPush(8'h42);
        busRead(32'h0003_0000);
        checkByte("rx_pop0", bif.bus_dout_out, 8'h41);
        busRead(32'h0003_0000);
        checkByte("rx_pop1", bif.bus_dout_out, 8'h42);
        busRead(32'h0003_0000);
        checkByte("rx_empty", bif.bus_dout_out, 8'h00);
        bif.rx_valid_in = 1'b1;
        bif.rx_data_in  = 8'h3C;
        busRead(32'h0003_0000);
        bif.rx_valid_in = 1'b0;
        checkByte("rx_empty_pushpop", bif.bus_dout_out, 8'h00);
        busRead(32'h0003_0000);
        checkByte("rx_after_pushpop", bif.bus_dout_out, 8'h3C);
        for (int i = 0; i < 9; i++) rxPush(8'(8'h10 + i));
        checkBit("rx_full", bif.rx_ready_out, 1'b0);
        for (int i = 0; i < 8; i++) begin
            busRead(32'h0003_0000);
            checkByte("rx_fill_order", bif.bus_dout_out, 8'(8'h10 + i));
        end
        busRead(32'h0003_0000);
        checkByte("rx_fill_drop", bif.bus_dout_out, 8'h00);
        checkBit("rx_ready_again", bif.rx_ready_out, 1'b1);

        // TX zero filter, other I/O address
        bif.tx_ready_in = 1'b1;
        busWrite(32'h0003_0000, 8'h00);
        checkBit("tx_zero_ign", bif.tx_valid_out, 1'b0);
        busWrite(32'h0003_0000, 8'h33);
        checkBit("tx_valid", bif.tx_valid_out, 1'b1);
        checkByte("tx_data", bif.tx_data_out, 8'h33);
        step();
        checkBit("tx_popped", bif.tx_valid_out, 1'b0);
        busWrite(32'h0003_0008, 8'h55);
        checkBit("io_other_wr", bif.tx_valid_out, 1'b0);
        busRead(32'h0000_0010);
        busRead(32'h0003_0008);
        checkByte("io_other_rd", bif.bus_dout_out, 8'h00);

        // TX backpressure and cpu_rdy gating
        bif.tx_ready_in = 1'b0;
        for (int i = 0; i < 7; i++) begin
            busWrite(32'h0003_0000, 8'(8'h51 + i));
            if (i < 6) checkBit("tx_rdy_hi", bif.cpu_rdy_out, 1'b1);
        end
        step();
        checkBit("tx_rdy_lo", bif.cpu_rdy_out, 1'b0);
        bif.tx_ready_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checkBit("tx_drain_valid", bif.tx_valid_out, 1'b1);
            checkByte("tx_drain_data", bif.tx_data_out, 8'(8'h51 + i));
            step();
        end
        checkBit("tx_drained", bif.tx_valid_out, 1'b0);
        checkBit("tx_rdy_back", bif.cpu_rdy_out, 1'b1);

        // TX overflow drop, then push+pop while full
        bif.tx_ready_in = 1'b0;
        for (int i = 0; i < 9; i++) busWrite(32'h0003_0000, 8'(8'h61 + i));
        checkBit("tx_full_rdy", bif.cpu_rdy_out, 1'b0);
        bif.tx_ready_in = 1'b1;
        checkByte("tx_full_head", bif.tx_data_out, 8'h61);
        busWrite(32'h0003_0000, 8'h70);
        for (int i = 0; i < 7; i++) begin
            checkByte("tx_full_order", bif.tx_data_out, 8'(8'h62 + i));
            step();
        end
        checkByte("tx_full_pushpop", bif.tx_data_out, 8'h70);
        step();
        checkBit("tx_full_end", bif.tx_valid_out, 1'b0);

        // Cycle counter snapshot taken just before a low-byte rollover
        budget = 0;
        while (tbCycles[7:0] != 8'hFE && budget < 600) begin
            step();
            budget++;
        end
        checkBit("cnt_sync", (budget < 600), 1'b1);
        snapN = tbCycles;
        busRead(32'h0003_0004);
        checkByte("cnt_b0", bif.bus_dout_out, snapN[7:0]);
        step();
        step();
        step();
        busRead(32'h0003_0005);
        checkByte("cnt_b1", bif.bus_dout_out, snapN[15:8]);
        busRead(32'h0003_0006);
        checkByte("cnt_b2", bif.bus_dout_out, snapN[23:16]);
        busRead(32'h0003_0007);
        checkByte("cnt_b3", bif.bus_dout_out, snapN[31:24]);

        // Halt: 0x00 pushed, later writes dropped, reads served
        busWrite(32'h0003_0004, 8'hAB);
        checkBit("halt_set", bif.halted_out, 1'b1);
        checkBit("halt_txvalid", bif.tx_valid_out, 1'b1);
        checkByte("halt_txdata", bif.tx_data_out, 8'h00);
        step();
        busWrite(32'h0000_0010, 8'h77);
        busWrite(32'h0003_0000, 8'h44);
        checkBit("halt_tx_drop", bif.tx_valid_out, 1'b0);
        busRead(32'h0000_0010);
        checkByte("halt_ram_drop", bif.bus_dout_out, 8'hA5);
        checkBit("halt_sticky", bif.halted_out, 1'b1);

        // Asynchronous reset mid-stream
        bif.tx_ready_in = 1'b0;
        rxPush(8'h21);
        rxPush(8'h22);
        #3;
        rst = 1'b1;
        #1;
        checkByte("arst_dout", bif.bus_dout_out, 8'h00);
        checkBit("arst_rdy", bif.cpu_rdy_out, 1'b0);
        checkBit("arst_rxrdy", bif.rx_ready_out, 1'b0);
        checkBit("arst_halted", bif.halted_out, 1'b0);
        checkBit("arst_txvalid", bif.tx_valid_out, 1'b0);
        step();
        rst = 1'b0;
        step();
        checkBit("arst_rel_rdy", bif.cpu_rdy_out, 1'b1);
        busRead(32'h0003_0000);
        checkByte("arst_rx_flushed", bif.bus_dout_out, 8'h00);
        busRead(32'h0000_0010);
        checkByte("arst_ram_kept", bif.bus_dout_out, 8'hA5);
        busWrite(32'h0003_0000, 8'h66);
        checkBit("arst_tx_live", bif.tx_valid_out, 1'b1);
        checkByte("arst_tx_data", bif.tx_data_out, 8'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
